// File: rtl/bitstream_fetch_ctrl.sv
// Secured-bitstream load sequencer: reads start/length from the bootloader, fetches memory
// words and packs them MSB-first into AES blocks handed to the decryptor.
module bitstream_fetch_ctrl #(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_LENGTH     = 32,
    parameter int AES_DATA_LENGTH = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       cfg_wr,
    output logic                       bl_rw,
    input  logic [ADDR_WIDTH-1:0]      bl_addr,
    input  logic [DATA_LENGTH-1:0]     bl_blocks,
    output logic                       mem_rd_en,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic [DATA_LENGTH-1:0]     mem_rdata,
    output logic [AES_DATA_LENGTH-1:0] aes_data,
    output logic                       aes_valid,
    input  logic                       aes_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err_len
);
    localparam int WPB    = AES_DATA_LENGTH / DATA_LENGTH;
    localparam int CW     = $clog2(WPB + 1);
    localparam int STAGES = 1;

    typedef enum logic [2:0] {IDLE, BL_RD, BL_WAIT, LATCH, FETCH, PUSH, DONE} state_t;

    state_t                                  state;
    logic [ADDR_WIDTH-1:0]                   addr_cnt;
    logic [DATA_LENGTH-1:0]                  blk_rem;
    logic [CW-1:0]                           cnt;
    logic [STAGES:0]                         vld_pipe;
    logic [CW:0]                             cnt_nx;
    logic                                    rd_more;
    logic [AES_DATA_LENGTH+DATA_LENGTH-1:0]  shift_cat;

    // vld_pipe[0] is the read strobe itself, vld_pipe[1] marks the cycle its data returns
    assign mem_rd_en = vld_pipe[0];
    assign mem_addr  = addr_cnt;
    assign bl_rw     = rst_n && (state == IDLE) && cfg_wr && !start;
    assign cnt_nx    = {1'b0, cnt} + 1'b1;
    assign rd_more   = cnt_nx < (CW+1)'(WPB);
    assign shift_cat = {aes_data, mem_rdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            blk_rem   <= '0;
            cnt       <= '0;
            vld_pipe  <= '0;
            aes_data  <= '0;
            aes_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            done    <= 1'b0;
            err_len <= 1'b0;
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (vld_pipe[0]) addr_cnt <= addr_cnt + 1'b1;
            if (vld_pipe[STAGES] && !abort) aes_data <= shift_cat[AES_DATA_LENGTH-1:0];
            if (abort) begin
                state     <= IDLE;
                vld_pipe  <= '0;
                aes_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state <= BL_RD;
                        busy  <= 1'b1;
                    end
                    BL_RD:   state <= BL_WAIT;
                    BL_WAIT: state <= LATCH;
                    LATCH: begin
                        addr_cnt <= bl_addr;
                        blk_rem  <= bl_blocks;
                        if (bl_blocks == '0) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            err_len <= 1'b1;
                        end else begin
                            state       <= FETCH;
                            cnt         <= '0;
                            vld_pipe[0] <= 1'b1;
                        end
                    end
                    FETCH: begin
                        cnt         <= cnt + 1'b1;
                        vld_pipe[0] <= rd_more;
                        if (cnt == CW'(WPB)) begin
                            state     <= PUSH;
                            aes_valid <= 1'b1;
                        end
                    end
                    PUSH: if (aes_ready) begin
                        aes_valid <= 1'b0;
                        blk_rem   <= blk_rem - 1'b1;
                        if (blk_rem == DATA_LENGTH'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= FETCH;
                            cnt         <= '0;
                            vld_pipe[0] <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bitstream_fetch_ctrl.sv
// Bench for bitstream_fetch_ctrl: timeline-based reference model plus directed literal checks.
module tb_bitstream_fetch_ctrl;
    localparam int AW = 8, DL = 32, AL = 128, WPB = AL / DL;

    logic clk = 0, rst_n = 0, start = 0, abort = 0, cfg_wr = 0, aes_ready = 0;
    logic [AW-1:0] bl_addr = '0;
    logic [DL-1:0] bl_blocks = '0;
    logic [DL-1:0] mem_rdata = '0;
    logic bl_rw, mem_rd_en, aes_valid, busy, done, err_len;
    logic [AW-1:0] mem_addr;
    logic [AL-1:0] aes_data;

    bitstream_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_LENGTH(DL), .AES_DATA_LENGTH(AL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_wr(cfg_wr),
        .bl_rw(bl_rw), .bl_addr(bl_addr), .bl_blocks(bl_blocks),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .aes_data(aes_data), .aes_valid(aes_valid), .aes_ready(aes_ready),
        .busy(busy), .done(done), .err_len(err_len)
    );

    always #5 clk = ~clk;

    logic [DL-1:0] mem [256];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int tests = 0, fails = 0;
    task automatic chk(input string name, input logic [AL-1:0] act, input logic [AL-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [AL-1:0] exp_block(input logic [AW-1:0] base);
        logic [AL-1:0] r = '0;
        for (int j = 0; j < WPB; j++) r = {r[AL-DL-1:0], mem[AW'(base + j)]};
        return r;
    endfunction

    // Reference model: a load is a timeline of cycle numbers. Start accepted at edge e gives
    // LATCH in cycle e+2; each block's fetch starts at cycle F, reads F..F+WPB-1, valid from
    // F+WPB+1 until its handshake; next fetch or done follows the handshake cycle.
    int cyc = 0, m_lat = -10, m_F = -10, m_done = -10, m_rem = 0;
    bit m_busy = 0, m_fetch = 0, m_err = 0;
    logic [AW-1:0] m_addr = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_fetch = 0; m_err = 0; m_lat = -10; m_F = -10; m_done = -10;
        end else begin
            int prev;
            bit was_busy;
            prev = cyc; cyc = cyc + 1; was_busy = m_busy;
            if (abort) begin
                m_busy = 0; m_fetch = 0; m_lat = -10; m_done = -10;
            end else begin
                if (m_fetch && prev >= m_F + WPB + 1 && aes_ready) begin
                    m_addr = m_addr + AW'(WPB);
                    m_rem  = m_rem - 1;
                    if (m_rem == 0) begin m_fetch = 0; m_done = cyc; end
                    else m_F = cyc;
                end
                if (m_busy && cyc == m_lat + 1) begin
                    m_addr = bl_addr;
                    m_rem  = int'(bl_blocks);
                    if (m_rem == 0) begin m_done = cyc; m_err = 1; end
                    else begin m_fetch = 1; m_F = cyc; end
                end
                if (m_busy && cyc == m_done + 1) m_busy = 0;
                if (!was_busy && start) begin
                    m_busy = 1; m_err = 0; m_lat = cyc + 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_outs", {bl_rw, mem_rd_en, aes_valid, busy, done, err_len}, '0);
            chk("rst_data", aes_data, '0);
        end else begin
            int k;
            bit e_rd, e_val;
            k = cyc - m_F;
            e_rd  = m_fetch && k >= 0 && k < WPB;
            e_val = m_fetch && k >= WPB + 1;
            chk("busy", busy, m_busy);
            chk("done", done, cyc == m_done);
            chk("err_len", err_len, (cyc == m_done) && m_err);
            chk("mem_rd_en", mem_rd_en, e_rd);
            if (e_rd) chk("mem_addr", mem_addr, AW'(m_addr + k));
            chk("aes_valid", aes_valid, e_val);
            if (e_val) chk("aes_data", aes_data, exp_block(m_addr));
            chk("bl_rw", bl_rw, !m_busy && cfg_wr && !start);
        end
    end

    logic [AW-1:0] rd_q[$];
    logic [AL-1:0] blk_q[$];
    int done_cnt = 0;
    always @(negedge clk) if (rst_n) begin
        if (mem_rd_en) rd_q.push_back(mem_addr);
        if (aes_valid && aes_ready) blk_q.push_back(aes_data);
        if (done) done_cnt++;
    end

    task automatic drive();
        @(posedge clk); #2;
    endtask

    task automatic kick(input logic [AW-1:0] a, input logic [DL-1:0] n);
        bl_addr = a; bl_blocks = n; rd_q.delete(); blk_q.delete(); done_cnt = 0;
        start = 1; drive(); start = 0;
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (done_cnt == 0 && n < max) begin drive(); n++; end
        if (done_cnt == 0) chk({name, "_timeout"}, 1'b0, 1'b1);
        drive();
    endtask

    task automatic wait_valid(input string name, input int max);
        int n = 0;
        while (!aes_valid && n < max) begin drive(); n++; end
        chk({name, "_valid_seen"}, aes_valid, 1'b1);
    endtask

    initial begin
        logic [AL-1:0] held;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = DL'(i);
        repeat (3) drive();
        rst_n = 1;
        drive();

        // 1: two blocks from 0x10, ready always high
        aes_ready = 1;
        drive(); kick(8'h10, 2); wait_done("t1", 60);
        chk("t1_nreads", rd_q.size(), 8);
        if (rd_q.size() == 8) begin
            chk("t1_rd_first", rd_q[0], 8'h10);
            chk("t1_rd_last", rd_q[7], 8'h17);
        end
        chk("t1_nblk", blk_q.size(), 2);
        if (blk_q.size() == 2) begin
            chk("t1_blk0", blk_q[0], 128'h00000010_00000011_00000012_00000013);
            chk("t1_blk1", blk_q[1], 128'h00000014_00000015_00000016_00000017);
        end

        // 2: zero length -> done+err_len 4 cycles after start, no reads
        bl_addr = 8'h40; bl_blocks = 0; rd_q.delete(); done_cnt = 0;
        start = 1; n = 0;
        @(posedge clk); #2; start = 0; n = 1;
        while (!done && n < 20) begin @(posedge clk); #2; n++; end
        chk("t2_latency", n, 4);
        chk("t2_err", err_len, 1'b1);
        drive();
        chk("t2_nreads", rd_q.size(), 0);

        // 3: address wrap
        drive(); kick(8'hFE, 1); wait_done("t3", 40);
        chk("t3_nreads", rd_q.size(), 4);
        if (rd_q.size() == 4)
            chk("t3_addrs", {rd_q[0], rd_q[1], rd_q[2], rd_q[3]}, 32'hFEFF0001);
        if (blk_q.size() == 1)
            chk("t3_blk", blk_q[0], 128'h000000FE_000000FF_00000000_00000001);
        else chk("t3_nblk", blk_q.size(), 1);

        // 4: back-pressure holds the block
        aes_ready = 0;
        drive(); kick(8'h20, 1); wait_valid("t4", 30);
        held = aes_data;
        repeat (5) drive();
        chk("t4_held_data", aes_data, held);
        chk("t4_held_valid", aes_valid, 1'b1);
        chk("t4_no_extra_reads", rd_q.size(), 4);
        aes_ready = 1; wait_done("t4", 20);

        // 5: abort in 2nd fetch of 3-block load, then clean rerun
        drive(); kick(8'h30, 3);
        n = 0;
        while (rd_q.size() < 5 && n < 40) begin drive(); n++; end
        chk("t5_in_fetch2", rd_q.size(), 5);
        abort = 1; drive(); abort = 0;
        chk("t5_busy_after_abort", busy, 1'b0);
        chk("t5_valid_after_abort", aes_valid, 1'b0);
        repeat (10) drive();
        chk("t5_no_done", done_cnt, 0);
        chk("t5_blocks_before_abort", blk_q.size(), 1);
        kick(8'h50, 1); wait_done("t5_rerun", 40);
        chk("t5_rerun_nblk", blk_q.size(), 1);

        // 6: cfg_wr passthrough, reset mid-PUSH
        cfg_wr = 1; drive();
        chk("t6_bl_rw_idle", bl_rw, 1'b1);
        cfg_wr = 0; aes_ready = 0;
        kick(8'h60, 2);
        n = 0;
        while (!mem_rd_en && n < 10) begin drive(); n++; end
        cfg_wr = 1; #1;
        chk("t6_bl_rw_fetch", bl_rw, 1'b0);
        cfg_wr = 0;
        wait_valid("t6", 20);
        #1 rst_n = 0; #1;
        chk("t6_async_rst", {bl_rw, mem_rd_en, aes_valid, busy, done, err_len}, '0);
        chk("t6_async_rst_data", aes_data, '0);
        drive(); rst_n = 1; drive();

        // random phase
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int c = 0; c < 4000; c++) begin
            if (!m_busy) begin
                bl_addr   = AW'($urandom);
                bl_blocks = DL'($urandom_range(0, 3));
            end
            start     = ($urandom_range(0, 3) == 0);
            aes_ready = ($urandom_range(0, 2) != 0);
            cfg_wr    = $urandom_range(0, 1);
            abort     = ($urandom_range(0, 150) == 0);
            drive();
        end
        start = 0; abort = 0; cfg_wr = 0; aes_ready = 1;
        repeat (40) drive();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
